cond_stage: RTL and testbench

Execute-stage condition unit merged with the E→M control pipeline register. It holds the NZCV flag register and evaluates each instruction's 4-bit ARM condition against the stored flags. It gates the instruction's control bits and registers them into the Memory stage, supporting stall, flush and bubble insertion. Its M-side outputs feed the M→W control register directly.

---
 rtl/cond_stage.sv | 107 ++++++++++
 tb/tb_cond_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_stage.sv
// Execute-stage condition evaluation plus NZCV flag register and E->M control register.
// Latency: CondExE/BranchTakenE combinational; flags and M controls update on the next edge.
// Backpressure: StallM freezes flags and M; StallE/FlushE insert a bubble and block flag writes.
module cond_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] CondE,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagWriteE,
    input  logic       PCSrcE,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    input  logic       MemWriteE,
    input  logic       BranchE,
    input  logic       StallE,
    input  logic       StallM,
    input  logic       FlushE,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemtoRegM,
    output logic       MemWriteM,
    output logic       CondExE,
    output logic       BranchTakenE,
    output logic [3:0] FlagsQ
);

    logic [3:0] flags_q, flags_d;
    logic       pcsrc_m_q, pcsrc_m_d;
    logic       regwrite_m_q, regwrite_m_d;
    logic       memtoreg_m_q, memtoreg_m_d;
    logic       memwrite_m_q, memwrite_m_d;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_base;
    logic       ok;

    // ARM conditions come in complementary pairs: evaluate the even one, invert on CondE[0].
    // The 111x pair evaluates to 1, so E passes and F never does.
    always_comb begin
        {flag_n, flag_z, flag_c, flag_v} = flags_q;
        cond_base = 1'b1;
        case (CondE[3:1])
            3'd0:    cond_base = flag_z;
            3'd1:    cond_base = flag_c;
            3'd2:    cond_base = flag_n;
            3'd3:    cond_base = flag_v;
            3'd4:    cond_base = flag_c & ~flag_z;
            3'd5:    cond_base = (flag_n == flag_v);
            3'd6:    cond_base = ~flag_z & (flag_n == flag_v);
            default: cond_base = 1'b1;
        endcase
        CondExE      = cond_base ^ CondE[0];
        ok           = CondExE & ~FlushE & ~StallE & ~StallM;
        BranchTakenE = BranchE & ok;
    end

    always_comb begin
        flags_d = flags_q;
        if (ok) begin
            if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // MemtoReg is left ungated; a squashed load cannot retire because RegWrite is gated.
    always_comb begin
        pcsrc_m_d    = pcsrc_m_q;
        regwrite_m_d = regwrite_m_q;
        memtoreg_m_d = memtoreg_m_q;
        memwrite_m_d = memwrite_m_q;
        if (!StallM) begin
            if (FlushE || StallE) begin
                pcsrc_m_d    = 1'b0;
                regwrite_m_d = 1'b0;
                memtoreg_m_d = 1'b0;
                memwrite_m_d = 1'b0;
            end else begin
                pcsrc_m_d    = PCSrcE & CondExE;
                regwrite_m_d = RegWriteE & CondExE;
                memtoreg_m_d = MemtoRegE;
                memwrite_m_d = MemWriteE & CondExE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q      <= 4'b0000;
            pcsrc_m_q    <= 1'b0;
            regwrite_m_q <= 1'b0;
            memtoreg_m_q <= 1'b0;
            memwrite_m_q <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            pcsrc_m_q    <= pcsrc_m_d;
            regwrite_m_q <= regwrite_m_d;
            memtoreg_m_q <= memtoreg_m_d;
            memwrite_m_q <= memwrite_m_d;
        end
    end

    assign FlagsQ    = flags_q;
    assign PCSrcM    = pcsrc_m_q;
    assign RegWriteM = regwrite_m_q;
    assign MemtoRegM = memtoreg_m_q;
    assign MemWriteM = memwrite_m_q;

endmodule

// File: tb/tb_cond_stage.sv
// Directed bench for cond_stage: flag latency, partial writes, stall/flush, full condition sweep.
module tb_cond_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] CondE;
    logic [3:0] ALUFlags;
    logic [1:0] FlagWriteE;
    logic       PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE;
    logic       StallE, StallM, FlushE;
    logic       PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic       CondExE, BranchTakenE;
    logic [3:0] FlagsQ;
    logic [3:0] m_bus;

    int total = 0;
    int bad   = 0;

    cond_stage dut (
        .clk          (clk),
        .reset        (reset),
        .CondE        (CondE),
        .ALUFlags     (ALUFlags),
        .FlagWriteE   (FlagWriteE),
        .PCSrcE       (PCSrcE),
        .RegWriteE    (RegWriteE),
        .MemtoRegE    (MemtoRegE),
        .MemWriteE    (MemWriteE),
        .BranchE      (BranchE),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushE       (FlushE),
        .PCSrcM       (PCSrcM),
        .RegWriteM    (RegWriteM),
        .MemtoRegM    (MemtoRegM),
        .MemWriteM    (MemWriteM),
        .CondExE      (CondExE),
        .BranchTakenE (BranchTakenE),
        .FlagsQ       (FlagsQ)
    );

    always #5 clk = ~clk;

    assign m_bus = {PCSrcM, RegWriteM, MemtoRegM, MemWriteM};

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("%s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("%s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ARM condition table, flags given as {N,Z,C,V}
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_e;
        CondE = 4'hE; ALUFlags = 4'h0; FlagWriteE = 2'b00;
        PCSrcE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; BranchE = 0;
        StallE = 0; StallM = 0; FlushE = 0;
    endtask

    initial begin
        reset = 1'b1;
        clear_e();
        #1;
        check1("reset_condex_al", CondExE, 1'b1);
        check4("reset_flags", FlagsQ, 4'b0000);
        check4("reset_m", m_bus, 4'b0000);
        tick();
        reset = 1'b0;

        // back-to-back flag set then EQ
        FlagWriteE = 2'b11; ALUFlags = 4'b0100;
        tick();
        check4("b2b_flags", FlagsQ, 4'b0100);
        FlagWriteE = 2'b00; CondE = 4'h0; RegWriteE = 1;
        #1;
        check1("b2b_eq_condex", CondExE, 1'b1);
        tick();
        check1("b2b_eq_regwrite", RegWriteM, 1'b1);
        CondE = 4'h1;
        tick();
        check1("b2b_ne_regwrite", RegWriteM, 1'b0);

        // instruction's own condition uses pre-update flags
        CondE = 4'h0; FlagWriteE = 2'b11; ALUFlags = 4'b0000;
        tick();
        check1("own_flags_regwrite", RegWriteM, 1'b1);
        check4("own_flags_new", FlagsQ, 4'b0000);
        FlagWriteE = 2'b00;
        #1;
        check1("own_flags_eq_now_fails", CondExE, 1'b0);

        // partial flag write
        clear_e();
        FlagWriteE = 2'b11; ALUFlags = 4'b1111;
        tick();
        check4("partial_setup", FlagsQ, 4'b1111);
        FlagWriteE = 2'b01; ALUFlags = 4'b0000;
        tick();
        check4("partial_cv_only", FlagsQ, 4'b1100);

        // load all-ones into M, then hold with StallM
        clear_e();
        PCSrcE = 1; RegWriteE = 1; MemtoRegE = 1; MemWriteE = 1;
        tick();
        check4("m_all_ones", m_bus, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            clear_e();
            StallM = 1; FlagWriteE = 2'b11; ALUFlags = 4'(i + 1); BranchE = 1;
            FlushE = (i == 2);
            #1;
            check1("stallm_no_branch", BranchTakenE, 1'b0);
            tick();
            check4("stallm_m_hold", m_bus, 4'b1111);
            check4("stallm_flags_hold", FlagsQ, 4'b1100);
        end

        // flush: bubble, no flag write, no branch
        clear_e();
        FlushE = 1; MemWriteE = 1; BranchE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0011;
        #1;
        check1("flush_no_branch", BranchTakenE, 1'b0);
        tick();
        check1("flush_memwrite", MemWriteM, 1'b0);
        check4("flush_flags", FlagsQ, 4'b1100);

        // flush together with StallE
        clear_e();
        PCSrcE = 1; RegWriteE = 1; MemtoRegE = 1; MemWriteE = 1;
        tick();
        FlushE = 1; StallE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0000;
        tick();
        check4("flush_stalle_bubble", m_bus, 4'b0000);
        check4("flush_stalle_flags", FlagsQ, 4'b1100);

        // branch taken, then the same branch under StallE
        clear_e();
        BranchE = 1; PCSrcE = 1;
        #1;
        check1("branch_taken", BranchTakenE, 1'b1);
        tick();
        check1("branch_pcsrcm", PCSrcM, 1'b1);
        StallE = 1;
        #1;
        check1("branch_stalle_taken", BranchTakenE, 1'b0);
        tick();
        check1("branch_stalle_pcsrcm", PCSrcM, 1'b0);

        // condition F: nothing passes except the ungated MemtoReg
        clear_e();
        CondE = 4'hF; RegWriteE = 1; MemWriteE = 1; MemtoRegE = 1; BranchE = 1; PCSrcE = 1;
        FlagWriteE = 2'b11; ALUFlags = 4'b0101;
        #1;
        check1("nv_condex", CondExE, 1'b0);
        check1("nv_branch", BranchTakenE, 1'b0);
        tick();
        check4("nv_m", m_bus, 4'b0010);
        check4("nv_flags", FlagsQ, 4'b1100);

        // full sweep of 16 conditions x 16 flag patterns
        for (int f = 0; f < 16; f++) begin
            clear_e();
            FlagWriteE = 2'b11; ALUFlags = 4'(f);
            tick();
            FlagWriteE = 2'b00;
            check4($sformatf("sweep_flags_%0h", f), FlagsQ, 4'(f));
            for (int c = 0; c < 16; c++) begin
                CondE = 4'(c);
                #1;
                check1($sformatf("sweep_c%0h_f%0h", c, f), CondExE, ref_cond(4'(c), 4'(f)));
            end
        end

        // explicit signed cases
        clear_e();
        FlagWriteE = 2'b11; ALUFlags = 4'b1001;
        tick();
        FlagWriteE = 2'b00; CondE = 4'hC;
        #1;
        check1("gt_n1_v1_z0", CondExE, 1'b1);
        FlagWriteE = 2'b11; CondE = 4'hE; ALUFlags = 4'b1000;
        tick();
        FlagWriteE = 2'b00; CondE = 4'hD;
        #1;
        check1("le_n1_v0", CondExE, 1'b1);

        // reset asserted mid-cycle with every E control high
        clear_e();
        PCSrcE = 1; RegWriteE = 1; MemtoRegE = 1; MemWriteE = 1; BranchE = 1;
        FlagWriteE = 2'b11; ALUFlags = 4'b1111;
        tick();
        check4("pre_reset_m", m_bus, 4'b1111);
        check4("pre_reset_flags", FlagsQ, 4'b1111);
        #2;
        reset = 1'b1;
        #1;
        check4("async_reset_m", m_bus, 4'b0000);
        check4("async_reset_flags", FlagsQ, 4'b0000);
        check1("async_reset_condex", CondExE, 1'b1);
        #1;
        reset = 1'b0;
        ALUFlags = 4'b0110;
        tick();
        check4("post_reset_m", m_bus, 4'b1111);
        check4("post_reset_flags", FlagsQ, 4'b0110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
